// File: rtl/btb_2bit_predictor.sv
// rtl/btb_2bit_predictor.sv - branch target buffer with 2-bit counters and true-LRU replacement
//
// Purpose: per-cycle fetch-group prediction (hit, direction, target, valid-slot
// mask, next R0) from a fully associative table trained by one update port.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   inv_all          clear every valid bit (ages, counters, targets kept)
//   lk_pc            fetch-group base address
//   lk_hit           per-slot tag hit
//   lk_taken         per-slot predicted taken (hit and counter MSB)
//   lk_target        per-slot target, slot i in [i*ADDR_W +: ADDR_W], 0 on miss
//   lk_slot_v        slots up to and including the first taken slot
//   lk_next_pc       first taken target, else sequential group address
//   upd_valid        resolved-branch update strobe
//   upd_pc           resolved branch address
//   upd_taken        resolved direction
//   upd_target       resolved target
//   entries_used     number of valid entries
module btb_2bit_predictor #(
    parameter int ENTRIES     = 8,
    parameter int ADDR_W      = 16,
    parameter int FETCH_W     = 2,
    parameter int INSTR_BYTES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inv_all,
    input  logic [ADDR_W-1:0]             lk_pc,
    output logic [FETCH_W-1:0]            lk_hit,
    output logic [FETCH_W-1:0]            lk_taken,
    output logic [FETCH_W*ADDR_W-1:0]     lk_target,
    output logic [FETCH_W-1:0]            lk_slot_v,
    output logic [ADDR_W-1:0]             lk_next_pc,
    input  logic                          upd_valid,
    input  logic [ADDR_W-1:0]             upd_pc,
    input  logic                          upd_taken,
    input  logic [ADDR_W-1:0]             upd_target,
    output logic [$clog2(ENTRIES+1)-1:0]  entries_used
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(ENTRIES+1);
    localparam logic [ADDR_W-1:0] GROUP_STEP = ADDR_W'(FETCH_W * INSTR_BYTES);
    localparam logic [IDX_W-1:0]  OLDEST     = IDX_W'(ENTRIES - 1);

    logic [ENTRIES-1:0] valid_q;
    logic [ADDR_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [IDX_W-1:0]   age_q    [ENTRIES];

    logic               upd_hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   victim_idx;
    logic [IDX_W-1:0]   alloc_idx;
    logic [IDX_W-1:0]   touch_idx;
    logic               touch_en;

    // Lookup: tags are unique, so at most one entry matches each slot.
    always_comb begin
        logic [ADDR_W-1:0] slot_pc;
        logic              taken_seen;
        lk_hit     = '0;
        lk_taken   = '0;
        lk_target  = '0;
        lk_slot_v  = '0;
        lk_next_pc = lk_pc + GROUP_STEP;
        taken_seen = 1'b0;
        slot_pc    = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            slot_pc = lk_pc + ADDR_W'(i * INSTR_BYTES);
            for (int j = 0; j < ENTRIES; j++) begin
                if (valid_q[j] && tag_q[j] == slot_pc) begin
                    lk_hit[i]                     = 1'b1;
                    lk_taken[i]                   = ctr_q[j][1];
                    lk_target[i*ADDR_W +: ADDR_W] = target_q[j];
                end
            end
        end
        // Slots after the first predicted-taken branch are squashed.
        for (int i = 0; i < FETCH_W; i++) begin
            if (!taken_seen) begin
                lk_slot_v[i] = 1'b1;
                if (lk_taken[i]) begin
                    lk_next_pc = lk_target[i*ADDR_W +: ADDR_W];
                    taken_seen = 1'b1;
                end
            end
        end
    end

    // Update-side match, free-slot search and LRU victim.
    always_comb begin
        upd_hit    = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        victim_idx = '0;
        for (int j = 0; j < ENTRIES; j++) begin
            if (valid_q[j] && tag_q[j] == upd_pc) begin
                upd_hit = 1'b1;
                hit_idx = IDX_W'(j);
            end
            if (!valid_q[j] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(j);
            end
            if (age_q[j] == OLDEST) begin
                victim_idx = IDX_W'(j);
            end
        end
        alloc_idx = free_found ? free_idx : victim_idx;
        touch_idx = upd_hit ? hit_idx : alloc_idx;
        // A not-taken miss leaves the table, including ages, untouched.
        touch_en  = upd_hit || upd_taken;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            entries_used <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
                age_q[i]    <= IDX_W'(i);
            end
        end else if (inv_all) begin
            valid_q      <= '0;
            entries_used <= '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[hit_idx] != 2'b11) begin
                        ctr_q[hit_idx] <= ctr_q[hit_idx] + 2'd1;
                    end
                    target_q[hit_idx] <= upd_target;
                end else if (ctr_q[hit_idx] != 2'b00) begin
                    ctr_q[hit_idx] <= ctr_q[hit_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_q[alloc_idx]  <= 1'b1;
                tag_q[alloc_idx]    <= upd_pc;
                target_q[alloc_idx] <= upd_target;
                ctr_q[alloc_idx]    <= 2'b10;
                if (free_found) begin
                    entries_used <= entries_used + CNT_W'(1);
                end
            end
            if (touch_en) begin
                for (int k = 0; k < ENTRIES; k++) begin
                    if (IDX_W'(k) == touch_idx) begin
                        age_q[k] <= '0;
                    end else if (age_q[k] < age_q[touch_idx]) begin
                        age_q[k] <= age_q[k] + IDX_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_btb_2bit_predictor.sv
// tb/tb_btb_2bit_predictor.sv - scoreboard bench for btb_2bit_predictor
module tb_btb_2bit_predictor;

    logic        clk;
    logic        rst;
    logic        inv_all;
    logic [15:0] lk_pc;
    logic [1:0]  lk_hit;
    logic [1:0]  lk_taken;
    logic [31:0] lk_target;
    logic [1:0]  lk_slot_v;
    logic [15:0] lk_next_pc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic [2:0]  entries_used;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [1:0]  hit;
        logic [1:0]  taken;
        logic [1:0]  slot_v;
        logic [15:0] next_pc;
        logic [31:0] target;
        logic [2:0]  used;
    } exp_t;

    exp_t exp_q[$];

    btb_2bit_predictor #(
        .ENTRIES(4), .ADDR_W(16), .FETCH_W(2), .INSTR_BYTES(2)
    ) dut (
        .clk(clk), .rst(rst), .inv_all(inv_all), .lk_pc(lk_pc),
        .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target),
        .lk_slot_v(lk_slot_v), .lk_next_pc(lk_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .entries_used(entries_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".hit"},    32'(lk_hit),       32'(e.hit));
            chk({e.name, ".taken"},  32'(lk_taken),     32'(e.taken));
            chk({e.name, ".slot_v"}, 32'(lk_slot_v),    32'(e.slot_v));
            chk({e.name, ".next"},   32'(lk_next_pc),   32'(e.next_pc));
            chk({e.name, ".target"}, lk_target,         e.target);
            chk({e.name, ".used"},   32'(entries_used), 32'(e.used));
        end
    end

    task automatic expect_lk(input string name, input logic [15:0] pc,
                             input logic [1:0] hit, input logic [1:0] taken,
                             input logic [1:0] slot_v, input logic [15:0] next_pc,
                             input logic [31:0] target, input logic [2:0] used);
        exp_t e;
        lk_pc = pc;
        e.name = name; e.hit = hit; e.taken = taken; e.slot_v = slot_v;
        e.next_pc = next_pc; e.target = target; e.used = used;
        exp_q.push_back(e);
    endtask

    task automatic lookup(input string name, input logic [15:0] pc,
                          input logic [1:0] hit, input logic [1:0] taken,
                          input logic [1:0] slot_v, input logic [15:0] next_pc,
                          input logic [31:0] target, input logic [2:0] used);
        expect_lk(name, pc, hit, taken, slot_v, next_pc, target, used);
        @(posedge clk); #1;
    endtask

    task automatic upd(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inv_all = 1'b0; lk_pc = 16'h0010;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        lookup("reset", 16'h0010, 2'b00, 2'b00, 2'b11, 16'h0014, 32'h0, 3'd0);

        // single taken branch in slot 1, then slot 0
        upd(16'h0012, 1'b1, 16'h0040);
        lookup("slot1", 16'h0010, 2'b10, 2'b10, 2'b11, 16'h0040, 32'h0040_0000, 3'd1);
        upd(16'h0010, 1'b1, 16'h0080);
        lookup("slot0", 16'h0010, 2'b11, 2'b11, 2'b01, 16'h0080, 32'h0040_0080, 3'd2);

        // counter hysteresis on 0x0012 (looked up as slot 0)
        upd(16'h0012, 1'b0, 16'h0000);
        upd(16'h0012, 1'b0, 16'h0000);
        lookup("ctr0", 16'h0012, 2'b01, 2'b00, 2'b11, 16'h0016, 32'h0000_0040, 3'd2);
        upd(16'h0012, 1'b1, 16'h0040);
        lookup("ctr1", 16'h0012, 2'b01, 2'b00, 2'b11, 16'h0016, 32'h0000_0040, 3'd2);
        upd(16'h0012, 1'b1, 16'h0040);
        lookup("ctr2", 16'h0012, 2'b01, 2'b01, 2'b01, 16'h0040, 32'h0000_0040, 3'd2);
        upd(16'h0012, 1'b1, 16'h0044);
        upd(16'h0012, 1'b1, 16'h0044);
        upd(16'h0012, 1'b0, 16'h0000);
        lookup("sat_nt1", 16'h0012, 2'b01, 2'b01, 2'b01, 16'h0044, 32'h0000_0044, 3'd2);
        upd(16'h0012, 1'b0, 16'h0000);
        lookup("sat_nt2", 16'h0012, 2'b01, 2'b00, 2'b11, 16'h0016, 32'h0000_0044, 3'd2);

        // reset mid-sequence, then LRU replacement on a fresh table
        do_reset();
        lookup("rst_mid", 16'h0010, 2'b00, 2'b00, 2'b11, 16'h0014, 32'h0, 3'd0);
        upd(16'h0100, 1'b1, 16'h1100);
        upd(16'h0200, 1'b1, 16'h1200);
        upd(16'h0300, 1'b1, 16'h1300);
        upd(16'h0400, 1'b1, 16'h1400);
        upd(16'h0100, 1'b1, 16'h1100);
        upd(16'h0500, 1'b1, 16'h1500);
        lookup("lru_B", 16'h0200, 2'b00, 2'b00, 2'b11, 16'h0204, 32'h0, 3'd4);
        lookup("lru_A", 16'h0100, 2'b01, 2'b01, 2'b01, 16'h1100, 32'h0000_1100, 3'd4);
        lookup("lru_C", 16'h0300, 2'b01, 2'b01, 2'b01, 16'h1300, 32'h0000_1300, 3'd4);
        lookup("lru_D", 16'h0400, 2'b01, 2'b01, 2'b01, 16'h1400, 32'h0000_1400, 3'd4);
        lookup("lru_E", 16'h0500, 2'b01, 2'b01, 2'b01, 16'h1500, 32'h0000_1500, 3'd4);

        // not-taken miss: no allocation and no age change, so C is next victim
        upd(16'h0600, 1'b0, 16'h1600);
        lookup("nt_miss", 16'h0600, 2'b00, 2'b00, 2'b11, 16'h0604, 32'h0, 3'd4);
        upd(16'h0700, 1'b1, 16'h1700);
        lookup("evict_C", 16'h0300, 2'b00, 2'b00, 2'b11, 16'h0304, 32'h0, 3'd4);
        lookup("keep_D",  16'h0400, 2'b01, 2'b01, 2'b01, 16'h1400, 32'h0000_1400, 3'd4);

        // inv_all with a coincident update: update is dropped
        inv_all = 1'b1;
        upd(16'h0800, 1'b1, 16'h1800);
        inv_all = 1'b0;
        lookup("inv_A", 16'h0100, 2'b00, 2'b00, 2'b11, 16'h0104, 32'h0, 3'd0);
        lookup("inv_D", 16'h0400, 2'b00, 2'b00, 2'b11, 16'h0404, 32'h0, 3'd0);
        lookup("inv_upd", 16'h0800, 2'b00, 2'b00, 2'b11, 16'h0804, 32'h0, 3'd0);
        upd(16'h0900, 1'b1, 16'h1900);
        lookup("post_inv", 16'h0900, 2'b01, 2'b01, 2'b01, 16'h1900, 32'h0000_1900, 3'd1);

        // wrap-around, with a same-cycle lookup that must not see the update
        do_reset();
        expect_lk("no_bypass", 16'hFFFE, 2'b00, 2'b00, 2'b11, 16'h0002, 32'h0, 3'd0);
        upd(16'h0000, 1'b1, 16'h2222);
        lookup("wrap", 16'hFFFE, 2'b10, 2'b10, 2'b11, 16'h2222, 32'h2222_0000, 3'd1);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_2bit_predictor.md
# btb_2bit_predictor

Parametrised branch target buffer with 2-bit saturating direction counters and true-LRU replacement, serving a FETCH_W-wide fetch group per cycle. It sits between the fetch-stage R0 register and the execute/branch-resolve logic. Fetch gets a same-cycle prediction of slot hits, taken/not-taken, per-slot targets, the valid-slot mask and the next R0. Execute trains the table through a single update port.

## Interface
- ENTRIES, 8: table depth; power of two, at least 2.
- ADDR_W, 16: PC/target width.
- FETCH_W, 2: instructions looked up per cycle.
- INSTR_BYTES, 2: byte stride between fetch slots.
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- inv_all  in  1  invalidate every entry (branch-state flush).
- lk_pc  in  ADDR_W  fetch-group base address (current R0).
- lk_hit  out  FETCH_W  bit i: slot i address matches a valid entry.
- lk_taken  out  FETCH_W  bit i: lk_hit[i] and counter MSB set.
- lk_target  out  FETCH_W*ADDR_W  slot i target in bits [i*ADDR_W +: ADDR_W]; 0 when not hit.
- lk_slot_v  out  FETCH_W  slots 0..k valid, where k is the first taken slot; all ones if none.
- lk_next_pc  out  ADDR_W  predicted next R0.
- upd_valid  in  1  resolved-branch update strobe.
- upd_pc  in  ADDR_W  resolved branch address.
- upd_taken  in  1  resolved direction.
- upd_target  in  ADDR_W  resolved target.
- entries_used  out  $clog2(ENTRIES+1)  count of valid entries.

## Operation
- Per-entry state: valid, tag (full ADDR_W PC), target, ctr[1:0], age[$clog2(ENTRIES)-1:0].
- Lookup is combinational from registered state.
  - Slot i address = lk_pc + i*INSTR_BYTES, mod 2^ADDR_W.
  - Hit requires valid and tag equality.
  - lk_next_pc = lk_target of the lowest taken slot; otherwise lk_pc + FETCH_W*INSTR_BYTES, wrapping mod 2^ADDR_W.
- Update on upd_valid, when upd_pc hits:
  - ctr saturating increment if taken, decrement if not taken; range 0..3.
  - target <= upd_target only if taken.
  - Entry touched.
- Update on upd_valid, when upd_pc misses and taken:
  - Allocate the lowest-index invalid entry; if none, the entry with age == ENTRIES-1.
  - Write tag, target; ctr <= 2'b10 (weakly taken); valid <= 1.
  - Entry touched.
- Update on upd_valid, when upd_pc misses and not taken: no state change.
- Touch of entry j: every entry with age < age[j] increments; age[j] <= 0. Ages therefore stay a permutation of 0..ENTRIES-1 at all times.
- Tags are unique by construction, since allocation happens only on a miss.
- inv_all clears all valid bits. Ages, ctr and targets are retained.
- entries_used tracks valid-bit population: +1 on allocation into an invalid entry, 0 on inv_all/rst, unchanged on victim replacement.

## Timing
- Priority at posedge: rst > inv_all > upd_valid. An update coincident with inv_all is dropped.
- Reset values:
  - All valid=0, ctr=2'b01, target=0, tag=0, age[i]=i; entries_used=0.
  - After reset: lk_hit=0, lk_taken=0, lk_target=0, lk_slot_v=all ones, lk_next_pc=lk_pc+FETCH_W*INSTR_BYTES.
- Lookup latency 0 cycles.
- Update visible to lookup on the cycle after the upd_valid edge.
- No bypass: a same-cycle lookup of upd_pc sees pre-update state.
- One update per cycle, accepted unconditionally; no back-pressure.
- Wrap-around: slot addresses and lk_next_pc wrap at 2^ADDR_W, e.g. lk_pc=16'hFFFE, FETCH_W=2 gives slot 1 = 16'h0000.

## Test plan
All scenarios use ENTRIES=4, FETCH_W=2, INSTR_BYTES=2.
1. Reset, lk_pc=16'h0010 -> lk_hit=0, lk_slot_v=2'b11, lk_next_pc=16'h0014, entries_used=0.
2. Update pc=16'h0012 taken target=16'h0040, then lk_pc=16'h0010 -> lk_hit=2'b10, lk_taken=2'b10, lk_slot_v=2'b11, lk_next_pc=16'h0040. Repeat with pc=16'h0010 -> lk_slot_v=2'b01.
3. Counter hysteresis on pc=16'h0012:
   - Two not-taken updates -> lk_taken[1]=0 (ctr=0).
   - One taken update -> still 0 (ctr=1).
   - Second taken update -> 1 (ctr=2).
   - Further taken updates saturate at 3.
4. LRU replacement:
   - Allocate taken branches A,B,C,D = 0x100,0x200,0x300,0x400, then touch A.
   - Allocate E=0x500 -> B evicted: lookup of 0x200 misses, A/C/D/E hit, entries_used=4.
5. Not-taken miss update at 0x600 -> no allocation, entries_used unchanged.
6. Boundary and reset events:
   - inv_all with simultaneous upd_valid -> all lookups miss next cycle, entries_used=0.
   - rst mid-sequence -> scenario 1 values.
   - lk_pc=16'hFFFE with a taken entry at 16'h0000 -> lk_hit=2'b10, lk_next_pc=that entry's target.
